// File: rtl/mem_access_stage_pkg.sv
// Shared types and encodings for the memory access stage.
// Imported by the stage top, its bus interface and the write-back mux.
package mem_access_stage_pkg;

  typedef logic [15:0] data_t;
  typedef logic [3:0]  reg_addr_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_RAM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IH  = 2'b11;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// RAM/serial bus with a req/ack handshake.
// The stage is the master; the memory side is the slave.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic  ram_req;
  logic  ram_we;
  data_t ram_addr;
  data_t ram_wdata;
  data_t ram_rdata;
  logic  ram_ack;

  modport master (
    output ram_req, ram_we,
    output ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_req, ram_we,
    input  ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );

endinterface

// File: rtl/mem_access_stage_wb_data_mux.sv
// Write-back source select on DATA_OP.
// Purely combinational 4:1 mux.
module wb_data_mux
  import mem_access_stage_pkg::*;
(
  input  logic [1:0] i_sel,
  input  data_t      i_alu,
  input  data_t      i_ram,
  input  data_t      i_pc,
  input  data_t      i_ih,
  output data_t      o_data
);

  always_comb begin
    o_data = i_alu;
    unique case (i_sel)
      WB_ALU: o_data = i_alu;
      WB_RAM: o_data = i_ram;
      WB_PC:  o_data = i_pc;
      WB_IH:  o_data = i_ih;
      default: o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs loads/stores on the req/ack bus, stalls upstream,
// serves the serial status word locally and aborts hung accesses.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int    WAIT_MAX       = 15,
  parameter data_t UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_MEM_RAM_EN,
  input  logic        EXE_MEM_RAM_OP,
  input  logic [1:0]  EXE_MEM_DATA_OP,
  input  logic        EXE_MEM_REG_OP,
  input  data_t       EXE_MEM_ALU_ANSWER,
  input  data_t       EXE_MEM_RAM_WB_DATA,
  input  data_t       EXE_MEM_PC,
  input  data_t       EXE_MEM_IH,
  input  reg_addr_t   EXE_MEM_WB_ADDR,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  mem_access_stage_if.master bus,
  output logic        MEM_STALL,
  output logic        MEM_ERR,
  output data_t       NEW_MEM_WB_DATA,
  output reg_addr_t   NEW_MEM_WB_ADDR,
  output logic        NEW_MEM_WB_REG_OP
);

  localparam logic [7:0] W_LAST = 8'(WAIT_MAX - 1);

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  logic       r_req;
  logic       r_we;
  data_t      r_addr;
  data_t      r_wdata;
  data_t      r_rdata;
  logic [7:0] r_wait_cnt;
  logic       r_err;

  logic  w_stat_rd;
  logic  w_bus_go;
  logic  w_timeout;
  data_t w_ram_src;
  data_t w_stat_word;

  assign w_stat_rd = EXE_MEM_RAM_EN
                   & (EXE_MEM_RAM_OP == RAM_RD)
                   & (EXE_MEM_ALU_ANSWER == UART_STAT_ADDR);
  assign w_bus_go  = EXE_MEM_RAM_EN & ~w_stat_rd;
  assign w_timeout = ~bus.ram_ack & (r_wait_cnt == W_LAST);

  assign w_stat_word = {14'b0, uart_data_ready, uart_tbre & uart_tsre};

  always_comb begin
    w_state_nxt = r_state;
    MEM_STALL   = 1'b0;
    w_ram_src   = 16'h0000;
    unique case (r_state)
      S_IDLE: begin
        MEM_STALL = w_bus_go;
        if (w_stat_rd) w_ram_src = w_stat_word;
        if (w_bus_go) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        MEM_STALL = 1'b1;
        if (bus.ram_ack || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ram_src   = r_rdata;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ack outranks a timeout landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_bus_go) begin
            r_req      <= 1'b1;
            r_we       <= EXE_MEM_RAM_OP;
            r_addr     <= EXE_MEM_ALU_ANSWER;
            r_wdata    <= EXE_MEM_RAM_WB_DATA;
            r_wait_cnt <= '0;
          end
        end
        S_ACCESS: begin
          if (bus.ram_ack) begin
            r_req <= 1'b0;
            if (r_we == RAM_RD) r_rdata <= bus.ram_rdata;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= 16'hFFFF;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  wb_data_mux u_wb_mux (
    .i_sel  (EXE_MEM_DATA_OP),
    .i_alu  (EXE_MEM_ALU_ANSWER),
    .i_ram  (w_ram_src),
    .i_pc   (EXE_MEM_PC),
    .i_ih   (EXE_MEM_IH),
    .o_data (NEW_MEM_WB_DATA)
  );

  assign NEW_MEM_WB_ADDR   = EXE_MEM_WB_ADDR;
  assign NEW_MEM_WB_REG_OP = EXE_MEM_REG_OP & ~MEM_STALL;
  assign MEM_ERR           = r_err;

  assign bus.ram_req   = r_req;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
// Bus slave is modelled inline; expected values are hand-computed.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en, ram_op, reg_op;
  logic [1:0]  data_op;
  logic [15:0] alu, st_data, pc, ih;
  logic [3:0]  wb_addr;
  logic        u_dr, u_tbre, u_tsre;
  logic        stall, err, wb_reg_op;
  logic [15:0] wb_data;
  logic [3:0]  wb_waddr;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage #(
    .WAIT_MAX       (15),
    .UART_STAT_ADDR (16'hBF01)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXE_MEM_RAM_EN      (ram_en),
    .EXE_MEM_RAM_OP      (ram_op),
    .EXE_MEM_DATA_OP     (data_op),
    .EXE_MEM_REG_OP      (reg_op),
    .EXE_MEM_ALU_ANSWER  (alu),
    .EXE_MEM_RAM_WB_DATA (st_data),
    .EXE_MEM_PC          (pc),
    .EXE_MEM_IH          (ih),
    .EXE_MEM_WB_ADDR     (wb_addr),
    .uart_data_ready     (u_dr),
    .uart_tbre           (u_tbre),
    .uart_tsre           (u_tsre),
    .bus                 (bus),
    .MEM_STALL           (stall),
    .MEM_ERR             (err),
    .NEW_MEM_WB_DATA     (wb_data),
    .NEW_MEM_WB_ADDR     (wb_waddr),
    .NEW_MEM_WB_REG_OP   (wb_reg_op)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic set_in(input logic en, input logic op,
                        input logic [1:0] dop, input logic rop,
                        input logic [15:0] a, input logic [15:0] sd,
                        input logic [3:0] wa);
    ram_en = en; ram_op = op; data_op = dop; reg_op = rop;
    alu = a; st_data = sd; wb_addr = wa;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called right after inputs are set in IDLE; returns in DONE.
  task automatic run_bus(input int ack_k, input logic [15:0] rd,
                         output int stalls, output int bubbles,
                         output int req_bad, output int errs,
                         output logic we, output logic [15:0] a,
                         output logic [15:0] wd);
    stalls = 0; bubbles = 0; req_bad = 0; errs = 0;
    we = 1'b0; a = '0; wd = '0;
    #1;
    if (stall) stalls++;
    if (stall && wb_reg_op) bubbles++;
    if (bus.ram_req) req_bad++;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (!stall) break;
      stalls++;
      if (wb_reg_op) bubbles++;
      if (!bus.ram_req) req_bad++;
      if (err) errs++;
      if (n == 1) begin
        we = bus.ram_we; a = bus.ram_addr; wd = bus.ram_wdata;
      end
      bus.ram_ack   = (n == ack_k);
      bus.ram_rdata = (n == ack_k) ? rd : 16'h0000;
    end
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = 16'h0000;
  endtask

  int st, bb, rb, ec;
  logic we_o;
  logic [15:0] a_o, wd_o;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 2'b00, 0, 16'h0, 16'h0, 4'h0);
    pc = 16'h0100; ih = 16'h0200;
    u_dr = 0; u_tbre = 0; u_tsre = 0;
    bus.ram_ack = 1'b0; bus.ram_rdata = 16'h0;
    step(); step();
    chk("rst_req",   {31'b0, bus.ram_req}, 0);
    chk("rst_we",    {31'b0, bus.ram_we}, 0);
    chk("rst_addr",  {16'b0, bus.ram_addr}, 0);
    chk("rst_wdata", {16'b0, bus.ram_wdata}, 0);
    chk("rst_err",   {31'b0, err}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    rst = 1'b0;

    // ALU pass-through and other wb sources
    set_in(0, 0, 2'b00, 1, 16'h1234, 16'h0, 4'd3);
    #1;
    chk("alu_data",  {16'b0, wb_data}, 32'h1234);
    chk("alu_addr",  {28'b0, wb_waddr}, 3);
    chk("alu_regop", {31'b0, wb_reg_op}, 1);
    chk("alu_stall", {31'b0, stall}, 0);
    data_op = 2'b01; #1;
    chk("ram_noen",  {16'b0, wb_data}, 0);
    data_op = 2'b10; #1;
    chk("pc_data",   {16'b0, wb_data}, 32'h0100);
    data_op = 2'b11; #1;
    chk("ih_data",   {16'b0, wb_data}, 32'h0200);
    step();

    // load, ack in 3rd ACCESS cycle
    set_in(1, 0, 2'b01, 1, 16'h8000, 16'h0, 4'd5);
    run_bus(3, 16'hBEEF, st, bb, rb, ec, we_o, a_o, wd_o);
    chk("ld_stalls", st, 4);
    chk("ld_bubble", bb, 0);
    chk("ld_req",    rb, 0);
    chk("ld_we",     {31'b0, we_o}, 0);
    chk("ld_addr",   {16'b0, a_o}, 32'h8000);
    chk("ld_data",   {16'b0, wb_data}, 32'hBEEF);
    chk("ld_regop",  {31'b0, wb_reg_op}, 1);
    chk("ld_reqoff", {31'b0, bus.ram_req}, 0);
    chk("ld_err",    {31'b0, err}, 0);

    // back-to-back store, ack in 1st ACCESS cycle
    step();
    set_in(1, 1, 2'b00, 0, 16'h4000, 16'h00AA, 4'd2);
    run_bus(1, 16'h5555, st, bb, rb, ec, we_o, a_o, wd_o);
    chk("st_stalls", st, 2);
    chk("st_req",    rb, 0);
    chk("st_we",     {31'b0, we_o}, 1);
    chk("st_addr",   {16'b0, a_o}, 32'h4000);
    chk("st_wdata",  {16'b0, wd_o}, 32'h00AA);
    chk("st_regop",  {31'b0, wb_reg_op}, 0);
    chk("st_wbaddr", {28'b0, wb_waddr}, 2);

    // serial status read
    step();
    set_in(1, 0, 2'b01, 1, 16'hBF01, 16'h0, 4'd7);
    u_dr = 1; u_tbre = 1; u_tsre = 1;
    #1;
    chk("stat_data",  {16'b0, wb_data}, 32'h0003);
    chk("stat_stall", {31'b0, stall}, 0);
    chk("stat_regop", {31'b0, wb_reg_op}, 1);
    u_dr = 0; u_tsre = 0; #1;
    chk("stat_tx",    {16'b0, wb_data}, 32'h0000);
    u_dr = 1; u_tbre = 1; u_tsre = 0; #1;
    chk("stat_rx",    {16'b0, wb_data}, 32'h0002);
    step();
    chk("stat_noreq", {31'b0, bus.ram_req}, 0);
    chk("stat_stall2", {31'b0, stall}, 0);

    // timeout: no ack
    set_in(1, 0, 2'b01, 1, 16'h8002, 16'h0, 4'd4);
    run_bus(0, 16'h0, st, bb, rb, ec, we_o, a_o, wd_o);
    chk("to_stalls", st, 16);
    chk("to_req",    rb, 0);
    chk("to_errstl", ec, 0);
    chk("to_err",    {31'b0, err}, 1);
    chk("to_data",   {16'b0, wb_data}, 32'hFFFF);
    chk("to_reqoff", {31'b0, bus.ram_req}, 0);
    step();
    set_in(0, 0, 2'b00, 0, 16'h0, 16'h0, 4'd0);
    #1;
    chk("to_errone", {31'b0, err}, 0);

    // ack on the final allowed cycle beats the timeout
    set_in(1, 0, 2'b01, 1, 16'h8004, 16'h0, 4'd6);
    run_bus(15, 16'h2468, st, bb, rb, ec, we_o, a_o, wd_o);
    chk("edge_stalls", st, 16);
    chk("edge_err",    {31'b0, err}, 0);
    chk("edge_data",   {16'b0, wb_data}, 32'h2468);
    step();

    // reset in 2nd ACCESS cycle, then a clean load
    set_in(1, 0, 2'b01, 1, 16'h9000, 16'h0, 4'd1);
    step();
    chk("rs_req1", {31'b0, bus.ram_req}, 1);
    step();
    chk("rs_req2", {31'b0, bus.ram_req}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(0, 0, 2'b00, 1, 16'h0042, 16'h0, 4'd1);
    #1;
    chk("rs_req",   {31'b0, bus.ram_req}, 0);
    chk("rs_err",   {31'b0, err}, 0);
    chk("rs_stall", {31'b0, stall}, 0);
    chk("rs_data",  {16'b0, wb_data}, 32'h0042);
    step();
    set_in(1, 0, 2'b01, 1, 16'h9002, 16'h0, 4'd8);
    run_bus(2, 16'h1357, st, bb, rb, ec, we_o, a_o, wd_o);
    chk("rs_ld_stalls", st, 3);
    chk("rs_ld_addr",   {16'b0, a_o}, 32'h9002);
    chk("rs_ld_data",   {16'b0, wb_data}, 32'h1357);
    chk("rs_ld_err",    {31'b0, err}, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
